// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment constants are active-low in the order {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  // Value and decimal points travel together so a frame always sees a matched pair.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup; every nibble value is covered so no default is needed for completeness.
  always_comb begin
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-atomic updates.
// A load goes to a shadow register and is promoted to the display register only
// at a frame boundary, so one scan frame never shows two different values.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shows); without it all four digits display.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          boundary;
  scan_state_t   state_q;
  scan_state_t   state_d;
  disp_t         shadow;
  disp_t         display;
  logic          pending;
  logic [3:0]    nibble;
  logic          digit_dp;
  logic          blank;
  logic [6:0]    dec_seg;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (state_q == SCAN_D3);

  // Prescaler: free-running 0..CLK_DIV-1, one tick per digit slot.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in) begin
    if (!reset_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Scan state register.
  always_ff @(posedge clock_in) begin
    if (!reset_n) state_q <= SCAN_D0;
    else          state_q <= state_d;
  end

  // Next scan state: rotate D0->D1->D2->D3->D0, only on tick.
  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (tick) state_d = scan_state_t'(state_q + 2'd1);
  end

  // Shadow/display double buffer; a load on the boundary tick skips the shadow.
  // NOTE: display storage is reset too, because it drives visible outputs right after release.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (load && boundary) begin
      display <= '{value: value_in, dp: dp_in};
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= '{value: value_in, dp: dp_in};
        pending <= 1'b1;
      end
    end
  end

  // Select the nibble, decimal point and blanking for the current slot.
  always_comb begin
    nibble   = display.value[3:0];
    digit_dp = display.dp[0];
    blank    = 1'b0;
    case (state_q)
      SCAN_D1: begin nibble = display.value[7:4];   digit_dp = display.dp[1]; end
      SCAN_D2: begin nibble = display.value[11:8];  digit_dp = display.dp[2]; end
      SCAN_D3: begin nibble = display.value[15:12]; digit_dp = display.dp[3]; end
      default: ;
    endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
    case (state_q)
      SCAN_D1: blank = (display.value[15:4]  == 12'h000);
      SCAN_D2: blank = (display.value[15:8]  == 8'h00);
      SCAN_D3: blank = (display.value[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
  end

  ssd_hex_decoder u_hex_decoder (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Output registers: updated only on tick so they hold steady for a full slot.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        an  <= ~(4'b0001 << state_q);
        seg <= blank ? SEG_BLANK : dec_seg;
        dp  <= ~digit_dp;
      end
    end
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, giving the clock_in cycles per digit slot; legal range 2..2^20.
REQ-002 The block SHALL have port clock_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port value_in, input, 16 bits: the value to display as 4 hex digits, digit 0 = bits [3:0].
REQ-005 The block SHALL have port load, input, 1 bit: active-high strobe that captures value_in and dp_in.
REQ-006 The block SHALL have port dp_in, input, 4 bits: active-high per-digit decimal points.
REQ-007 The block SHALL have port seg, output, 7 bits: active-low segments, order {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-009 The block SHALL have port an, output, 4 bits: active-low digit enables, one-hot-low.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-011 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick is asserted in the cycle in which the count equals CLK_DIV-1.
REQ-012 The scan FSM SHALL have states SCAN_D0..SCAN_D3 and advance D0->D1->D2->D3->D0 on tick only.
REQ-013 A frame boundary is the tick that takes SCAN_D3 to SCAN_D0; frame_done SHALL pulse high in the cycle after that tick.
REQ-014 A load SHALL write value_in and dp_in into a shadow register and set a pending flag; if several loads occur before a boundary, the last one wins.
REQ-015 At a frame boundary with pending set, the shadow register SHALL be copied to the display register and pending cleared, so a frame never mixes two values.
REQ-016 A load coinciding with the boundary tick SHALL bypass the shadow: value_in and dp_in go directly to the display register and pending is cleared.
REQ-017 seg, dp and an SHALL be registered and SHALL reflect the new state one clock_in cycle after the tick.
REQ-018 an SHALL drive exactly one bit low: the bit indexed by the current state.
REQ-019 seg SHALL show the hex encoding 0-F of the current display nibble: standard A, lowercase b, C, lowercase d, E, F.
REQ-020 dp SHALL equal the inverse of display dp bit [state].
REQ-021 No output SHALL glitch between ticks; the outputs are constant for CLK_DIV cycles per slot.

Reset
REQ-022 While reset_n=0 at a clock edge, the block SHALL force: prescaler 0, state SCAN_D0, shadow and display 0, pending 0, an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
REQ-023 The first tick after reset release SHALL occur CLK_DIV cycles after release; an then becomes 4'b1110 one cycle later.
REQ-024 A reset asserted mid-frame or mid-pending SHALL discard the pending value; no frame_done pulse is emitted.

Configuration
REQ-025 Macro SSD_LEADING_ZERO_BLANK_EN: when defined, digits above the most significant non-zero digit SHALL have seg=7'h7F, except that digit 0 always displays, and dp still follows dp_in; when undefined, all 4 digits display normally.

Structure
REQ-026 Package ssd_pkg SHALL hold NUM_DIGITS=4, the state enumeration, SEG_BLANK=7'h7F and the 16 segment constants.
REQ-027 Hex-to-segment decoding SHALL be the combinational sub-module ssd_hex_decoder (4-bit in, 7-bit active-low out).

Verification (CLK_DIV=4)
REQ-028 Reset 5 cycles, then release -> an=1111 and seg=7F during reset; an=1110 from cycle 5 after release.
REQ-029 load with value_in=16'h12AF, dp_in=4'b0100; run 2 frames -> the second frame shows digit0 seg=F (7'h0E), digit1 A (7'h08), digit2 2 (7'h24) with dp=0, digit3 1 (7'h79).
REQ-030 load 16'h1111 then 16'h2222 within one frame -> the next frame shows only 2s; no frame mixes 1s and 2s.
REQ-031 load asserted exactly on the boundary tick with value 16'hBEEF -> digit0 of the immediately following frame shows F.
REQ-032 Reset asserted mid-frame with pending set -> after release the display shows 0000 and no frame_done pulse occurs before the first full frame.
REQ-033 With SSD_LEADING_ZERO_BLANK_EN, value 16'h0005 -> digits 3..1 have seg=7F and digit 0 shows 5; value 16'h0000 -> only digit 0 shows 0.
